// File: rtl/riscv_pkg.sv
// Shared definitions for the pipeline: exception causes, access sizes,
// writeback source encodings and the memory-stage state type.
package riscv_pkg;

   localparam logic [3:0] ECAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] ECAUSE_LOAD_FAULT       = 4'd5;
   localparam logic [3:0] ECAUSE_STORE_MISALIGNED = 4'd6;
   localparam logic [3:0] ECAUSE_STORE_FAULT      = 4'd7;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [1:0] WS_ALU  = 2'b00;
   localparam logic [1:0] WS_LOAD = 2'b01;
   localparam logic [1:0] WS_CSR  = 2'b10;
   localparam logic [1:0] WS_PC4  = 2'b11;

   typedef enum logic {
      STATE_IDLE = 1'b0,
      STATE_WAIT = 1'b1
   } memState_e;

   // Size 11 falls into the word rule.
   function automatic logic isAligned(input logic [1:0] size, input logic [1:0] offset);
      logic ok;
      case (size)
         SIZE_BYTE: ok = 1'b1;
         SIZE_HALF: ok = (offset[0] == 1'b0);
         default:   ok = (offset == 2'b00);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_align.sv
// Moves the addressed byte/half of a bus word down to bit 0 and
// sign- or zero-extends it to 32 bits.
module load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   output logic [31:0] result_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted  = rdata_i >> {offset_i, 3'b000};
      result_o = shifted;
      case (size_i)
         SIZE_BYTE: result_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
         SIZE_HALF: result_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
         default:   result_o = shifted;
      endcase
   end

endmodule

// File: rtl/memory.sv
// Memory-access pipeline stage: issues load/store bus transactions, holds the
// pipeline while one is outstanding, and registers results for writeback.
module memory
   import riscv_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           pc_in,
   input  logic [31:0]           next_pc_in,
   input  logic [31:0]           alu_data_in,
   input  logic [31:0]           rs2_data_in,
   input  logic [31:0]           csr_data_in,
   input  logic                  branch_taken_in,
   input  logic                  load_in,
   input  logic                  store_in,
   input  logic [1:0]            load_store_size_in,
   input  logic                  load_signed_in,
   input  logic [1:0]            write_select_in,
   input  logic [4:0]            rd_address_in,
   input  logic [11:0]           csr_address_in,
   input  logic                  csr_write_in,
   input  logic                  mret_in,
   input  logic                  wfi_in,
   input  logic                  valid_in,
   input  logic                  exception_in,
   input  logic [3:0]            ecause_in,
   input  logic                  stall,
   input  logic                  invalidate,
   input  logic                  mem_ready,
   input  logic                  mem_error,
   input  logic [31:0]           mem_rdata,
   output logic                  mem_valid,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_strobe,
   output logic                  mem_busy,
   output logic [31:0]           pc_out,
   output logic [31:0]           next_pc_out,
   output logic [31:0]           alu_data_out,
   output logic [31:0]           load_data_out,
   output logic [31:0]           csr_data_out,
   output logic                  branch_taken_out,
   output logic [1:0]            write_select_out,
   output logic [4:0]            rd_address_out,
   output logic [11:0]           csr_address_out,
   output logic                  csr_write_out,
   output logic                  mret_out,
   output logic                  wfi_out,
   output logic                  valid_out,
   output logic                  exception_out,
   output logic [3:0]            ecause_out
);

   memState_e             state_q, state_d;
   logic                  memValid_q, memValid_d;
   logic                  memWrite_q, memWrite_d;
   logic [ADDR_WIDTH-1:0] memAddress_q, memAddress_d;
   logic [31:0]           memWdata_q, memWdata_d;
   logic [3:0]            memStrobe_q, memStrobe_d;
   logic [1:0]            offset_q, offset_d;
   logic [1:0]            size_q, size_d;
   logic                  signed_q, signed_d;
   logic                  kill_q, kill_d;

   logic [31:0]           pcOut_q, pcOut_d;
   logic [31:0]           nextPcOut_q, nextPcOut_d;
   logic [31:0]           aluOut_q, aluOut_d;
   logic [31:0]           loadData_q, loadData_d;
   logic [31:0]           csrData_q, csrData_d;
   logic                  branchTaken_q, branchTaken_d;
   logic [1:0]            writeSelect_q, writeSelect_d;
   logic [4:0]            rdAddress_q, rdAddress_d;
   logic [11:0]           csrAddress_q, csrAddress_d;
   logic                  csrWrite_q, csrWrite_d;
   logic                  mret_q, mret_d;
   logic                  wfi_q, wfi_d;
   logic                  validOut_q, validOut_d;
   logic                  exception_q, exception_d;
   logic [3:0]            ecause_q, ecause_d;

   logic                  memAccess;
   logic                  aligned;
   logic                  start;
   logic                  misaligned;
   logic [31:0]           storeData;
   logic [3:0]            storeStrobe;
   logic [31:0]           alignedLoad;

   assign memAccess  = valid_in && !invalidate && !exception_in && (load_in || store_in);
   assign aligned    = isAligned(load_store_size_in, alu_data_in[1:0]);
   assign start      = memAccess && aligned && (state_q == STATE_IDLE);
   assign misaligned = memAccess && !aligned;

   // Busy is forced low during reset so upstream never sees a stall from a dead request.
   assign mem_busy = !reset && (start || ((state_q == STATE_WAIT) && !mem_ready));

   always_comb begin
      storeData   = rs2_data_in;
      storeStrobe = 4'b1111;
      case (load_store_size_in)
         SIZE_BYTE: begin
            storeData   = {4{rs2_data_in[7:0]}};
            storeStrobe = 4'b0001 << alu_data_in[1:0];
         end
         SIZE_HALF: begin
            storeData   = {2{rs2_data_in[15:0]}};
            storeStrobe = 4'b0011 << alu_data_in[1:0];
         end
         default: begin
            storeData   = rs2_data_in;
            storeStrobe = 4'b1111;
         end
      endcase
   end

   load_align u_load_align (
      .rdata_i  (mem_rdata),
      .offset_i (offset_q),
      .size_i   (size_q),
      .signed_i (signed_q),
      .result_o (alignedLoad)
   );

   // Next-state and next-output logic for the IDLE/WAIT controller.
   always_comb begin
      state_d       = state_q;
      memValid_d    = memValid_q;
      memWrite_d    = memWrite_q;
      memAddress_d  = memAddress_q;
      memWdata_d    = memWdata_q;
      memStrobe_d   = memStrobe_q;
      offset_d      = offset_q;
      size_d        = size_q;
      signed_d      = signed_q;
      kill_d        = kill_q;
      pcOut_d       = pcOut_q;
      nextPcOut_d   = nextPcOut_q;
      aluOut_d      = aluOut_q;
      loadData_d    = loadData_q;
      csrData_d     = csrData_q;
      branchTaken_d = branchTaken_q;
      writeSelect_d = writeSelect_q;
      rdAddress_d   = rdAddress_q;
      csrAddress_d  = csrAddress_q;
      csrWrite_d    = csrWrite_q;
      mret_d        = mret_q;
      wfi_d         = wfi_q;
      validOut_d    = 1'b0;
      exception_d   = exception_q;
      ecause_d      = ecause_q;

      case (state_q)
         STATE_IDLE: begin
            validOut_d = valid_in && !invalidate && !start;
            if (start) begin
               state_d      = STATE_WAIT;
               memValid_d   = 1'b1;
               memWrite_d   = store_in;
               memAddress_d = {alu_data_in[ADDR_WIDTH-1:2], 2'b00};
               memWdata_d   = storeData;
               memStrobe_d  = store_in ? storeStrobe : 4'b1111;
               offset_d     = alu_data_in[1:0];
               size_d       = load_store_size_in;
               signed_d     = load_signed_in;
               kill_d       = 1'b0;
            end else if (!stall) begin
               pcOut_d       = pc_in;
               nextPcOut_d   = next_pc_in;
               aluOut_d      = alu_data_in;
               loadData_d    = 32'd0;
               csrData_d     = csr_data_in;
               branchTaken_d = branch_taken_in;
               writeSelect_d = write_select_in;
               rdAddress_d   = rd_address_in;
               csrAddress_d  = csr_address_in;
               csrWrite_d    = csr_write_in;
               mret_d        = mret_in;
               wfi_d         = wfi_in;
               exception_d   = exception_in || misaligned;
               if (misaligned) begin
                  ecause_d = store_in ? ECAUSE_STORE_MISALIGNED : ECAUSE_LOAD_MISALIGNED;
               end else begin
                  ecause_d = ecause_in;
               end
            end
         end
         STATE_WAIT: begin
            // A kill seen while waiting is remembered; the bus cycle itself always finishes.
            if (invalidate) begin
               kill_d = 1'b1;
            end
            if (mem_ready) begin
               state_d       = STATE_IDLE;
               memValid_d    = 1'b0;
               memWrite_d    = 1'b0;
               pcOut_d       = pc_in;
               nextPcOut_d   = next_pc_in;
               aluOut_d      = alu_data_in;
               loadData_d    = memWrite_q ? 32'd0 : alignedLoad;
               csrData_d     = csr_data_in;
               branchTaken_d = branch_taken_in;
               writeSelect_d = write_select_in;
               rdAddress_d   = rd_address_in;
               csrAddress_d  = csr_address_in;
               csrWrite_d    = csr_write_in;
               mret_d        = mret_in;
               wfi_d         = wfi_in;
               validOut_d    = !(kill_q || invalidate);
               exception_d   = mem_error;
               if (mem_error) begin
                  ecause_d = memWrite_q ? ECAUSE_STORE_FAULT : ECAUSE_LOAD_FAULT;
               end else begin
                  ecause_d = ecause_in;
               end
            end
         end
         default: state_d = STATE_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= STATE_IDLE;
         memValid_q    <= 1'b0;
         memWrite_q    <= 1'b0;
         memAddress_q  <= '0;
         memWdata_q    <= 32'd0;
         memStrobe_q   <= 4'd0;
         offset_q      <= 2'd0;
         size_q        <= 2'd0;
         signed_q      <= 1'b0;
         kill_q        <= 1'b0;
         pcOut_q       <= 32'd0;
         nextPcOut_q   <= 32'd0;
         aluOut_q      <= 32'd0;
         loadData_q    <= 32'd0;
         csrData_q     <= 32'd0;
         branchTaken_q <= 1'b0;
         writeSelect_q <= 2'd0;
         rdAddress_q   <= 5'd0;
         csrAddress_q  <= 12'd0;
         csrWrite_q    <= 1'b0;
         mret_q        <= 1'b0;
         wfi_q         <= 1'b0;
         validOut_q    <= 1'b0;
         exception_q   <= 1'b0;
         ecause_q      <= 4'd0;
      end else begin
         state_q       <= state_d;
         memValid_q    <= memValid_d;
         memWrite_q    <= memWrite_d;
         memAddress_q  <= memAddress_d;
         memWdata_q    <= memWdata_d;
         memStrobe_q   <= memStrobe_d;
         offset_q      <= offset_d;
         size_q        <= size_d;
         signed_q      <= signed_d;
         kill_q        <= kill_d;
         pcOut_q       <= pcOut_d;
         nextPcOut_q   <= nextPcOut_d;
         aluOut_q      <= aluOut_d;
         loadData_q    <= loadData_d;
         csrData_q     <= csrData_d;
         branchTaken_q <= branchTaken_d;
         writeSelect_q <= writeSelect_d;
         rdAddress_q   <= rdAddress_d;
         csrAddress_q  <= csrAddress_d;
         csrWrite_q    <= csrWrite_d;
         mret_q        <= mret_d;
         wfi_q         <= wfi_d;
         validOut_q    <= validOut_d;
         exception_q   <= exception_d;
         ecause_q      <= ecause_d;
      end
   end

   assign mem_valid        = memValid_q;
   assign mem_write        = memWrite_q;
   assign mem_address      = memAddress_q;
   assign mem_wdata        = memWdata_q;
   assign mem_strobe       = memStrobe_q;
   assign pc_out           = pcOut_q;
   assign next_pc_out      = nextPcOut_q;
   assign alu_data_out     = aluOut_q;
   assign load_data_out    = loadData_q;
   assign csr_data_out     = csrData_q;
   assign branch_taken_out = branchTaken_q;
   assign write_select_out = writeSelect_q;
   assign rd_address_out   = rdAddress_q;
   assign csr_address_out  = csrAddress_q;
   assign csr_write_out    = csrWrite_q;
   assign mret_out         = mret_q;
   assign wfi_out          = wfi_q;
   assign valid_out        = validOut_q;
   assign exception_out    = exception_q;
   assign ecause_out       = ecause_q;

endmodule

// File: tb/tb_memory.sv
// Directed bench for the memory stage: a table of single-cycle IDLE cases
// followed by hand-written bus transaction sequences.
module tb_memory;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in;
   logic        branch_taken_in, load_in, store_in, load_signed_in;
   logic [1:0]  load_store_size_in, write_select_in;
   logic [4:0]  rd_address_in;
   logic [11:0] csr_address_in;
   logic        csr_write_in, mret_in, wfi_in, valid_in, exception_in;
   logic [3:0]  ecause_in;
   logic        stall, invalidate, mem_ready, mem_error;
   logic [31:0] mem_rdata;
   logic        mem_valid, mem_write, mem_busy;
   logic [31:0] mem_address, mem_wdata;
   logic [3:0]  mem_strobe;
   logic [31:0] pc_out, next_pc_out, alu_data_out, load_data_out, csr_data_out;
   logic        branch_taken_out, csr_write_out, mret_out, wfi_out;
   logic [1:0]  write_select_out;
   logic [4:0]  rd_address_out;
   logic [11:0] csr_address_out;
   logic        valid_out, exception_out;
   logic [3:0]  ecause_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   memory #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
      .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in),
      .branch_taken_in(branch_taken_in), .load_in(load_in), .store_in(store_in),
      .load_store_size_in(load_store_size_in), .load_signed_in(load_signed_in),
      .write_select_in(write_select_in), .rd_address_in(rd_address_in),
      .csr_address_in(csr_address_in), .csr_write_in(csr_write_in),
      .mret_in(mret_in), .wfi_in(wfi_in), .valid_in(valid_in),
      .exception_in(exception_in), .ecause_in(ecause_in),
      .stall(stall), .invalidate(invalidate),
      .mem_ready(mem_ready), .mem_error(mem_error), .mem_rdata(mem_rdata),
      .mem_valid(mem_valid), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_strobe(mem_strobe), .mem_busy(mem_busy),
      .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
      .load_data_out(load_data_out), .csr_data_out(csr_data_out),
      .branch_taken_out(branch_taken_out), .write_select_out(write_select_out),
      .rd_address_out(rd_address_out), .csr_address_out(csr_address_out),
      .csr_write_out(csr_write_out), .mret_out(mret_out), .wfi_out(wfi_out),
      .valid_out(valid_out), .exception_out(exception_out), .ecause_out(ecause_out)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] alu;
      logic        ld;
      logic        st;
      logic [1:0]  size;
      logic        vld;
      logic        exc;
      logic [3:0]  ecause;
      logic        inv;
      logic        stl;
      logic [4:0]  rd;
      logic        expValid;
      logic        expExc;
      logic [3:0]  expEcause;
      logic [31:0] expPc;
      logic [4:0]  expRd;
   } vec_t;

   vec_t vecs[10];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic clearInputs();
      pc_in = 0; next_pc_in = 0; alu_data_in = 0; rs2_data_in = 0; csr_data_in = 0;
      branch_taken_in = 0; load_in = 0; store_in = 0; load_store_size_in = 2'b10;
      load_signed_in = 0; write_select_in = 0; rd_address_in = 0; csr_address_in = 0;
      csr_write_in = 0; mret_in = 0; wfi_in = 0; valid_in = 0; exception_in = 0;
      ecause_in = 0; stall = 0; invalidate = 0; mem_ready = 0; mem_error = 0; mem_rdata = 0;
   endtask

   // Drives one instruction at the falling edge so it is stable at the next rising edge.
   task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] alu, input logic ld,
                                input logic st, input logic [1:0] size, input logic sgn,
                                input logic [31:0] rs2);
      @(negedge clk);
      clearInputs();
      pc_in = pc; next_pc_in = pc + 4; alu_data_in = alu; rs2_data_in = rs2;
      load_in = ld; store_in = st; load_store_size_in = size; load_signed_in = sgn;
      valid_in = 1'b1; rd_address_in = 5'd9; write_select_in = 2'b01;
   endtask

   // Holds mem_ready low for waitCycles WAIT cycles, then completes on the following edge.
   task automatic completeAccess(input int waitCycles, input logic [31:0] rdata, input logic err);
      for (int i = 0; i < waitCycles; i++) begin
         @(negedge clk);
         #1 checkOutput("busyWhileWaiting", {31'd0, mem_busy}, 32'd1);
         checkOutput("validLowWhileWaiting", {31'd0, valid_out}, 32'd0);
      end
      @(negedge clk);
      mem_ready = 1'b1; mem_rdata = rdata; mem_error = err;
      @(posedge clk);
      #1;
   endtask

   initial begin
      clearInputs();
      reset = 1'b1;
      #12;
      checkOutput("resetValidOut", {31'd0, valid_out}, 32'd0);
      checkOutput("resetMemValid", {31'd0, mem_valid}, 32'd0);
      checkOutput("resetPcOut", pc_out, 32'd0);
      checkOutput("resetEcause", {28'd0, ecause_out}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      vecs[0] = '{32'h100, 32'h11,   0, 0, 2'd2, 1, 0, 4'd0, 0, 0, 5'd1,  1, 0, 4'd0, 32'h100, 5'd1};
      vecs[1] = '{32'h104, 32'h0,    0, 0, 2'd2, 1, 1, 4'd2, 0, 0, 5'd2,  1, 1, 4'd2, 32'h104, 5'd2};
      vecs[2] = '{32'h108, 32'h0,    0, 0, 2'd2, 1, 0, 4'd0, 0, 1, 5'd3,  1, 1, 4'd2, 32'h104, 5'd2};
      vecs[3] = '{32'h10C, 32'h0,    0, 0, 2'd2, 1, 0, 4'd0, 1, 0, 5'd4,  0, 0, 4'd0, 32'h10C, 5'd4};
      vecs[4] = '{32'h110, 32'h1002, 1, 0, 2'd2, 1, 0, 4'd0, 0, 0, 5'd5,  1, 1, 4'd4, 32'h110, 5'd5};
      vecs[5] = '{32'h114, 32'h2001, 0, 1, 2'd1, 1, 0, 4'd0, 0, 0, 5'd6,  1, 1, 4'd6, 32'h114, 5'd6};
      vecs[6] = '{32'h118, 32'h2001, 1, 0, 2'd1, 1, 1, 4'd1, 0, 0, 5'd7,  1, 1, 4'd1, 32'h118, 5'd7};
      vecs[7] = '{32'h11C, 32'h3,    1, 0, 2'd0, 0, 0, 4'd0, 0, 0, 5'd8,  0, 0, 4'd0, 32'h11C, 5'd8};
      vecs[8] = '{32'h120, 32'h2002, 0, 1, 2'd3, 1, 0, 4'd0, 0, 0, 5'd9,  1, 1, 4'd6, 32'h120, 5'd9};
      vecs[9] = '{32'h124, 32'h1001, 1, 0, 2'd0, 1, 0, 4'd0, 1, 0, 5'd10, 0, 0, 4'd0, 32'h124, 5'd10};

      foreach (vecs[i]) begin
         @(negedge clk);
         clearInputs();
         pc_in = vecs[i].pc; alu_data_in = vecs[i].alu; load_in = vecs[i].ld;
         store_in = vecs[i].st; load_store_size_in = vecs[i].size; valid_in = vecs[i].vld;
         exception_in = vecs[i].exc; ecause_in = vecs[i].ecause; invalidate = vecs[i].inv;
         stall = vecs[i].stl; rd_address_in = vecs[i].rd;
         #1 checkOutput($sformatf("vec%0d_busy", i), {31'd0, mem_busy}, 32'd0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d_valid", i), {31'd0, valid_out}, {31'd0, vecs[i].expValid});
         checkOutput($sformatf("vec%0d_exc", i), {31'd0, exception_out}, {31'd0, vecs[i].expExc});
         checkOutput($sformatf("vec%0d_ecause", i), {28'd0, ecause_out}, {28'd0, vecs[i].expEcause});
         checkOutput($sformatf("vec%0d_pc", i), pc_out, vecs[i].expPc);
         checkOutput($sformatf("vec%0d_rd", i), {27'd0, rd_address_out}, {27'd0, vecs[i].expRd});
         checkOutput($sformatf("vec%0d_memValid", i), {31'd0, mem_valid}, 32'd0);
      end

      // Word load, ready three cycles after issue.
      applyStimulus(32'h200, 32'h1000, 1, 0, 2'b10, 0, 32'h0);
      #1 checkOutput("wordLoadBusyAtStart", {31'd0, mem_busy}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("wordLoadMemValid", {31'd0, mem_valid}, 32'd1);
      checkOutput("wordLoadAddress", mem_address, 32'h1000);
      checkOutput("wordLoadStrobe", {28'd0, mem_strobe}, 32'hF);
      checkOutput("wordLoadWrite", {31'd0, mem_write}, 32'd0);
      completeAccess(2, 32'hDEADBEEF, 1'b0);
      checkOutput("wordLoadData", load_data_out, 32'hDEADBEEF);
      checkOutput("wordLoadValid", {31'd0, valid_out}, 32'd1);
      checkOutput("wordLoadPc", pc_out, 32'h200);
      checkOutput("wordLoadNextPc", next_pc_out, 32'h204);
      checkOutput("wordLoadDone", {31'd0, mem_valid}, 32'd0);

      // Signed and unsigned byte loads at offset 3.
      applyStimulus(32'h210, 32'h1003, 1, 0, 2'b00, 1, 32'h0);
      @(posedge clk);
      #1 checkOutput("byteLoadAddress", mem_address, 32'h1000);
      completeAccess(0, 32'h80FFFF7F, 1'b0);
      checkOutput("signedByteLoad", load_data_out, 32'hFFFFFF80);
      applyStimulus(32'h214, 32'h1003, 1, 0, 2'b00, 0, 32'h0);
      @(posedge clk);
      completeAccess(0, 32'h80FFFF7F, 1'b0);
      checkOutput("unsignedByteLoad", load_data_out, 32'h00000080);

      // Half store in the upper lane.
      applyStimulus(32'h220, 32'h2002, 0, 1, 2'b01, 0, 32'h1234ABCD);
      @(posedge clk);
      #1;
      checkOutput("halfStoreStrobe", {28'd0, mem_strobe}, 32'hC);
      checkOutput("halfStoreWdata", mem_wdata, 32'hABCDABCD);
      checkOutput("halfStoreWrite", {31'd0, mem_write}, 32'd1);
      checkOutput("halfStoreAddress", mem_address, 32'h2000);
      completeAccess(1, 32'h55555555, 1'b0);
      checkOutput("halfStoreLoadData", load_data_out, 32'd0);
      checkOutput("halfStoreValid", {31'd0, valid_out}, 32'd1);

      // Load bus error.
      applyStimulus(32'h230, 32'h1008, 1, 0, 2'b10, 0, 32'h0);
      @(posedge clk);
      completeAccess(1, 32'h0, 1'b1);
      checkOutput("loadFaultExc", {31'd0, exception_out}, 32'd1);
      checkOutput("loadFaultEcause", {28'd0, ecause_out}, 32'd5);

      // Invalidate while waiting: transaction still completes but is killed.
      applyStimulus(32'h240, 32'h1004, 1, 0, 2'b10, 0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      invalidate = 1'b1;
      @(negedge clk);
      invalidate = 1'b0;
      #1 checkOutput("killedStillBusy", {31'd0, mem_busy}, 32'd1);
      completeAccess(0, 32'h12345678, 1'b0);
      checkOutput("killedValid", {31'd0, valid_out}, 32'd0);
      checkOutput("killedMemValid", {31'd0, mem_valid}, 32'd0);

      // Asynchronous reset during WAIT.
      applyStimulus(32'h250, 32'h1000, 1, 0, 2'b10, 0, 32'h0);
      @(posedge clk);
      #1 checkOutput("preResetMemValid", {31'd0, mem_valid}, 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("asyncResetMemValid", {31'd0, mem_valid}, 32'd0);
      checkOutput("asyncResetBusy", {31'd0, mem_busy}, 32'd0);
      checkOutput("asyncResetPc", pc_out, 32'd0);
      checkOutput("asyncResetLoadData", load_data_out, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      clearInputs();
      pc_in = 32'h300; valid_in = 1'b1; rd_address_in = 5'd3;
      @(posedge clk);
      #1;
      checkOutput("postResetPc", pc_out, 32'h300);
      checkOutput("postResetValid", {31'd0, valid_out}, 32'd1);
      checkOutput("postResetMemValid", {31'd0, mem_valid}, 32'd0);

      @(negedge clk);
      clearInputs();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
